// File: rtl/tft_pkg.sv
// Shared constants and types for the pulse-ox waveform renderer.
// Panel geometry, trace band limits, colours and the buffer entry layout.
package tft_pkg;

  localparam int H_ACTIVE   = 800;
  localparam int V_ACTIVE   = 480;
  localparam int TRACE_TOP  = 112;
  localparam int TRACE_BOT  = 367;
  localparam int GRID_MID   = 240;
  localparam int GRID_PITCH = 80;
  localparam int AW         = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // One buffer column: vertical span covered between consecutive samples.
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } entry_t;

  localparam rgb_t TRACE_RGB = 24'h00FF00;
  localparam rgb_t GRID_RGB  = 24'h404040;
  localparam rgb_t BG_RGB    = 24'h000000;

  function automatic logic is_grid_col(input logic [15:0] c);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < H_ACTIVE; k += GRID_PITCH)
      if (c == 16'(k)) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/waveform_ram.sv
// Simple dual-port 800x16 column buffer: one write port, one registered
// read port; a same-address read and write returns the old word.
module waveform_ram
  import tft_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [H_ACTIVE];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/tft_waveform_renderer.sv
// Scrolling waveform renderer: stores min/max column spans of incoming
// samples and paints them, over a grid, into the TFT pixel stream.
module tft_waveform_renderer
  import tft_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sample_valid,
  input  logic [7:0]  i_sample,
  output logic        o_sample_ready,
  input  logic        i_hold,
  input  logic        i_VS,
  input  logic        i_DE,
  input  logic [15:0] i_row_pixel,
  input  logic [15:0] i_col_pixel,
  output logic [7:0]  o_Red,
  output logic [7:0]  o_Green,
  output logic [7:0]  o_Blue
);

  localparam int STAGES = 1;

  logic          ready_q;
  logic          vs_q;
  logic [AW-1:0] wp, base;
  logic [AW:0]   fill, disp_fill;
  logic [7:0]    prev;
  logic          accept;
  logic [7:0]    ref_smp;
  entry_t        wentry, rentry;
  logic [AW:0]   col_nxt, sum;
  logic [AW-1:0] raddr;
  logic [STAGES:0] vld_pipe;

  assign o_sample_ready = ready_q;
  assign accept = i_sample_valid && ready_q;

  // The very first sample has no predecessor, so it spans only itself.
  always_comb begin
    ref_smp   = (fill == '0) ? i_sample : prev;
    wentry.lo = (ref_smp < i_sample) ? ref_smp : i_sample;
    wentry.hi = (ref_smp < i_sample) ? i_sample : ref_smp;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_q   <= 1'b0;
      vs_q      <= 1'b1;
      wp        <= '0;
      base      <= '0;
      fill      <= '0;
      disp_fill <= '0;
      prev      <= '0;
    end else begin
      ready_q <= !i_hold;
      vs_q    <= i_VS;
      // Fill is frozen with base so a mid-frame sample never exposes stale columns.
      if (vs_q && !i_VS) begin
        base      <= wp;
        disp_fill <= fill;
      end
      if (accept) begin
        wp   <= (wp == AW'(H_ACTIVE - 1)) ? '0 : wp + 1'b1;
        prev <= i_sample;
        if (fill != (AW+1)'(H_ACTIVE)) fill <= fill + 1'b1;
      end
    end
  end

  // Prefetch the column shown next cycle; blanking prefetches column 0.
  always_comb begin
    col_nxt = i_DE ? (i_col_pixel[AW:0] + 11'd1) : '0;
    sum     = {1'b0, base} + col_nxt;
    raddr   = (sum >= 11'(H_ACTIVE)) ? AW'(sum - 11'(H_ACTIVE)) : sum[AW-1:0];
  end

  waveform_ram u_ram (
    .clk   (i_clk),
    .we    (accept),
    .waddr (wp),
    .wdata (wentry),
    .raddr (raddr),
    .rdata (rentry)
  );

  // vld_pipe[1] marks that the RAM read register holds a post-reset read.
  assign vld_pipe[0] = 1'b1;
  always_ff @(posedge i_clk) begin
    if (i_rst) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  logic       in_band, filled, trace, grid;
  logic [7:0] amp;
  rgb_t       pix;

  // Colour is a shallow decode of the registered RAM word and current row/column.
  always_comb begin
    in_band = (i_row_pixel >= 16'(TRACE_TOP)) && (i_row_pixel <= 16'(TRACE_BOT));
    amp     = 8'(16'(TRACE_BOT) - i_row_pixel);
    filled  = (i_col_pixel < 16'(H_ACTIVE)) &&
              (({5'b0, disp_fill} + i_col_pixel) >= 16'(H_ACTIVE));
    trace   = in_band && filled && (rentry.lo <= amp) && (amp <= rentry.hi);
    grid    = ((i_col_pixel < 16'(H_ACTIVE)) && is_grid_col(i_col_pixel)) ||
              (i_row_pixel == 16'(TRACE_TOP)) || (i_row_pixel == 16'(GRID_MID)) ||
              (i_row_pixel == 16'(TRACE_BOT));
    if (!(vld_pipe[STAGES] && i_DE)) pix = BG_RGB;
    else if (trace)                  pix = TRACE_RGB;
    else if (grid)                   pix = GRID_RGB;
    else                             pix = BG_RGB;
  end

  assign o_Red   = pix.r;
  assign o_Green = pix.g;
  assign o_Blue  = pix.b;

endmodule

// File: tb/tb_tft_waveform_renderer.sv
// Directed scoreboard bench for the waveform renderer: stimulus tasks queue
// hand-computed pixel colours, a negedge monitor pops and compares them.
module tb_tft_waveform_renderer;

  localparam logic [23:0] TR = 24'h00FF00;
  localparam logic [23:0] GR = 24'h404040;
  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample = '0;
  logic        sample_ready;
  logic        hold = 1'b0;
  logic        vs = 1'b1;
  logic        de = 1'b0;
  logic [15:0] row = '0;
  logic [15:0] col = '0;
  logic [7:0]  red, green, blue;
  logic        chk = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  logic [23:0] exp_q[$];
  string       name_q[$];
  logic [23:0] m_exp;
  string       m_nm;

  always #5 clk = ~clk;

  tft_waveform_renderer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample_valid (sample_valid),
    .i_sample       (sample),
    .o_sample_ready (sample_ready),
    .i_hold         (hold),
    .i_VS           (vs),
    .i_DE           (de),
    .i_row_pixel    (row),
    .i_col_pixel    (col),
    .o_Red          (red),
    .o_Green        (green),
    .o_Blue         (blue)
  );

  always @(negedge clk) begin
    if (chk) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pixel: got %06h with no expectation queued", {red, green, blue});
      end else begin
        m_exp = exp_q.pop_front();
        m_nm  = name_q.pop_front();
        if ({red, green, blue} === m_exp) n_pass++;
        else $display("FAIL %s: got %06h want %06h", m_nm, {red, green, blue}, m_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic px(input string nm, input int r, input int c, input logic [23:0] e);
    @(posedge clk); #1;
    de = (c != 0); col = (c == 0) ? 16'd0 : 16'(c - 1); row = 16'(r); chk = 1'b0;
    @(posedge clk); #1;
    de = 1'b1; col = 16'(c); row = 16'(r);
    exp_q.push_back(e); name_q.push_back(nm); chk = 1'b1;
    @(posedge clk); #1;
    de = 1'b0; col = '0; chk = 1'b0;
  endtask

  task automatic chk_ready(input string nm, input logic e);
    @(negedge clk);
    n_total++;
    if (sample_ready === e) n_pass++;
    else $display("FAIL %s: ready got %b want %b", nm, sample_ready, e);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] v);
    logic acc;
    acc = 1'b0;
    sample_valid = 1'b1; sample = v;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = sample_ready;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: ready got 0 want 1 for sample %0d", v);
    end
  endtask

  task automatic vs_fall();
    vs = 1'b0;
    @(posedge clk); #1;
    vs = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state: black output and no readiness while reset is held.
    repeat (2) @(posedge clk);
    #1;
    px("rst_pixel", 240, 80, BG);
    chk_ready("rst_ready", 1'b0);
    do_reset();
    chk_ready("ready_first_cycle", 1'b0);
    chk_ready("ready_after", 1'b1);

    // Single sample of 100.
    send(8'd100);
    vs_fall();
    px("s1_trace",    267, 799, TR);
    px("s1_above",    266, 799, BG);
    px("s1_below",    268, 799, BG);
    px("s1_c798",     267, 798, BG);
    px("s1_c0_grid",  267, 0,   GR);
    px("s1_top_grid", 112, 799, GR);
    px("s1_bot_grid", 367, 799, GR);
    px("s1_c400",     300, 400, GR);

    // Samples 50 then 150.
    do_reset();
    send(8'd50);
    send(8'd150);
    vs_fall();
    px("s2_lo_edge",  317, 799, TR);
    px("s2_hi_edge",  217, 799, TR);
    px("s2_mid",      250, 799, TR);
    px("s2_above",    216, 799, BG);
    px("s2_below",    318, 799, BG);
    px("s2_c798",     317, 798, TR);
    px("s2_c798_off", 316, 798, BG);

    // Sample accepted in the VS-fall cycle shows up one frame later.
    do_reset();
    send(8'd100);
    vs = 1'b0; sample_valid = 1'b1; sample = 8'd200;
    @(negedge clk);
    n_total++;
    if (sample_ready === 1'b1) n_pass++;
    else $display("FAIL vs_sample_ready: got %b want 1", sample_ready);
    @(posedge clk); #1;
    vs = 1'b1; sample_valid = 1'b0;
    px("vs_old_trace", 267, 799, TR);
    px("vs_new_hidden", 200, 799, BG);
    vs_fall();
    px("vs_new_shown", 200, 799, TR);
    px("vs_old_moved", 267, 798, TR);
    px("vs_c798_off",  200, 798, BG);

    // Reset mid-line: next pixel black, not ready, trace gone.
    @(posedge clk); #1;
    de = 1'b1; col = 16'd400; row = 16'd240;
    @(posedge clk); #1;
    col = 16'd401; rst = 1'b1;
    @(posedge clk); #1;
    col = 16'd402; rst = 1'b0;
    exp_q.push_back(BG); name_q.push_back("midrst_pixel"); chk = 1'b1;
    @(negedge clk);
    n_total++;
    if (sample_ready === 1'b0) n_pass++;
    else $display("FAIL midrst_ready: got %b want 0", sample_ready);
    @(posedge clk); #1;
    de = 1'b0; col = '0; chk = 1'b0;
    px("midrst_no_trace", 267, 799, BG);
    vs_fall();
    px("midrst_vs_no_trace", 200, 799, BG);
    send(8'd100);
    vs_fall();
    px("midrst_new_trace", 267, 799, TR);

    // Hold: no acceptance while frozen.
    do_reset();
    send(8'd100);
    hold = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b1; sample = 8'd77;
    chk_ready("hold_ready_early", 1'b0);
    repeat (97) @(posedge clk);
    #1;
    chk_ready("hold_ready_late", 1'b0);
    sample_valid = 1'b0; hold = 1'b0;
    vs_fall();
    px("hold_trace",    267, 799, TR);
    px("hold_no_write", 290, 799, BG);
    px("hold_grid",     240, 80,  GR);
    px("hold_bg",       0,   1,   BG);

    // 805 samples n mod 256: buffer wraps, fill saturates.
    do_reset();
    for (int n = 0; n < 805; n++) send(8'(n));
    vs_fall();
    px("wrap_c0_a",    363, 0,   TR);
    px("wrap_c0_b",    362, 0,   TR);
    px("wrap_c0_grid", 364, 0,   GR);
    px("wrap_c1_a",    361, 1,   TR);
    px("wrap_c1_off",  363, 1,   BG);
    px("wrap_c799_a",  332, 799, TR);
    px("wrap_c799_b",  331, 799, TR);
    px("wrap_c799_lo", 333, 799, BG);
    px("wrap_c799_hi", 330, 799, BG);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL leftover_expect: got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
